dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/debug data-memory arbiter.
// Handles byte/half/word lanes, misalignment and ack timeout.
module dmem_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dm_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [1:0] SZ_W = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_B = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  // owner/last_owner: 1 = debug port, 0 = CPU
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic we_q, we_d;
  logic sx_q, sx_d;
  logic err_q, err_d;
  logic [1:0] sz_q, sz_d;
  logic [3:0] be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] crd_q, crd_d;
  logic [31:0] drd_q, drd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic gnt_dbg;
  logic c_sx;
  logic c_mis;
  logic [1:0] c_sz;
  logic [3:0] c_be;
  logic [31:0] c_wd;
  logic [31:0] ld_val;
  logic [15:0] hw;
  logic [7:0] by;

  // Decode CPU size code into lane enables, store data and alignment
  always_comb begin
    c_sz = SZ_W;
    c_sx = 1'b0;
    case (cpu_dm_ctrl)
      3'b001: begin c_sz = SZ_H; c_sx = 1'b1; end
      3'b010: c_sz = SZ_H;
      3'b011: begin c_sz = SZ_B; c_sx = 1'b1; end
      3'b100: c_sz = SZ_B;
      default: c_sz = SZ_W;
    endcase
    c_be  = 4'b1111;
    c_wd  = cpu_wdata;
    c_mis = (cpu_addr[1:0] != 2'b00);
    case (c_sz)
      SZ_H: begin
        c_be  = cpu_addr[1] ? 4'b1100 : 4'b0011;
        c_wd  = {2{cpu_wdata[15:0]}};
        c_mis = cpu_addr[0];
      end
      SZ_B: begin
        c_be  = 4'b0001 << cpu_addr[1:0];
        c_wd  = {4{cpu_wdata[7:0]}};
        c_mis = 1'b0;
      end
      default: c_mis = (cpu_addr[1:0] != 2'b00);
    endcase
    gnt_dbg = dbg_req & (~cpu_req | ~last_q);
  end

  // Extract and extend the addressed lane of the returned word
  always_comb begin
    hw = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addr_q[1:0])
      2'd0: by = mem_rdata[7:0];
      2'd1: by = mem_rdata[15:8];
      2'd2: by = mem_rdata[23:16];
      default: by = mem_rdata[31:24];
    endcase
    case (sz_q)
      SZ_H: ld_val = {{16{sx_q & hw[15]}}, hw};
      SZ_B: ld_val = {{24{sx_q & by[7]}}, by};
      default: ld_val = mem_rdata;
    endcase
  end

  // Next-state and latched-request logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    sx_d    = sx_q;
    err_d   = err_q;
    sz_d    = sz_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req | dbg_req) begin
          owner_d = gnt_dbg;
          if (gnt_dbg) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            be_d    = 4'b1111;
            sz_d    = SZ_W;
            sx_d    = 1'b0;
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = c_wd;
            be_d    = c_be;
            sz_d    = c_sz;
            sx_d    = c_sx;
            err_d   = c_mis;
            if (c_mis) begin
              crd_d   = '0;
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          err_d   = 1'b0;
          state_d = S_DONE;
          if (owner_q) drd_d = mem_rdata;
          else crd_d = ld_val;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          if (owner_q) drd_d = '0;
          else crd_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      sz_q    <= SZ_W;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      drd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      sx_q    <= sx_d;
      err_q   <= err_d;
      sz_q    <= sz_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_be    = mem_en ? be_q : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == S_DONE) & ~owner_q;
  assign dbg_ready = (state_q == S_DONE) & owner_q;
  assign err       = (state_q == S_DONE) & err_q;
  assign cpu_rdata = crd_q;
  assign dbg_rdata = drd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data-memory arbiter.
// Lanes, round-robin, misalignment, timeout and reset abort.
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_dm_ctrl;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ready;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_dm_ctrl(cpu_dm_ctrl),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_set(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] c);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_dm_ctrl = c;
  endtask

  task automatic dbg_set(input logic we, input logic [31:0] a,
                         input logic [31:0] wd);
    dbg_req = 1'b1;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = wd;
  endtask

  // Called in the cycle where the request is first presented.
  task automatic txn(input string tag, input logic is_dbg,
                     input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic e_we, input logic [31:0] e_wd,
                     input logic [31:0] mrd, input logic [31:0] e_rd);
    tick();
    chk({tag, ".en"}, mem_en, 1'b1);
    chk({tag, ".addr"}, mem_addr, e_addr);
    chk({tag, ".be"}, mem_be, e_be);
    chk({tag, ".we"}, mem_we, e_we);
    if (e_we) chk({tag, ".wd"}, mem_wdata, e_wd);
    tick();
    chk({tag, ".en_wait"}, mem_en, 1'b0);
    chk({tag, ".rdy_wait"}, cpu_ready | dbg_ready, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = mrd;
    tick();
    mem_ack = 1'b0;
    chk({tag, ".cpu_rdy"}, cpu_ready, !is_dbg);
    chk({tag, ".dbg_rdy"}, dbg_ready, is_dbg);
    chk({tag, ".err"}, err, 1'b0);
    if (!e_we) begin
      if (is_dbg) chk({tag, ".drd"}, dbg_rdata, e_rd);
      else chk({tag, ".crd"}, cpu_rdata, e_rd);
    end
    if (is_dbg) dbg_req = 1'b0;
    else cpu_req = 1'b0;
    tick();
    chk({tag, ".rdy_off"}, cpu_ready | dbg_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_dm_ctrl = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    #2;
    chk("rst.en", mem_en, 1'b0);
    chk("rst.be", mem_be, 4'b0000);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.rdy", {cpu_ready, dbg_ready, err}, 3'b000);
    chk("rst.crd", cpu_rdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    cpu_set(0, 32'h104, 0, 3'b000);
    txn("lw", 0, 32'h104, 4'b1111, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("lw.hold", cpu_rdata, 32'hDEADBEEF);
    cpu_set(0, 32'h107, 0, 3'b011);
    txn("lb", 0, 32'h104, 4'b1000, 0, 0, 32'h80FF1234, 32'hFFFFFF80);
    cpu_set(0, 32'h107, 0, 3'b100);
    txn("lbu", 0, 32'h104, 4'b1000, 0, 0, 32'h80FF1234, 32'h00000080);
    cpu_set(0, 32'h106, 0, 3'b001);
    txn("lh", 0, 32'h104, 4'b1100, 0, 0, 32'h80011234, 32'hFFFF8001);
    cpu_set(0, 32'h106, 0, 3'b010);
    txn("lhu", 0, 32'h104, 4'b1100, 0, 0, 32'h80011234, 32'h00008001);
    cpu_set(1, 32'h202, 32'h0000ABCD, 3'b001);
    txn("sh", 0, 32'h200, 4'b1100, 1, 32'hABCDABCD, 0, 0);
    cpu_set(1, 32'h101, 32'h00000055, 3'b011);
    txn("sb", 0, 32'h100, 4'b0010, 1, 32'h55555555, 0, 0);
    cpu_set(0, 32'h108, 0, 3'b111);
    txn("lw111", 0, 32'h108, 4'b1111, 0, 0, 32'h0BADF00D, 32'h0BADF00D);

    dbg_set(0, 32'h13, 0);
    txn("dbg_rd", 1, 32'h10, 4'b1111, 0, 0, 32'h12345678, 32'h12345678);
    chk("dbg.crd_hold", cpu_rdata, 32'h0BADF00D);
    dbg_set(1, 32'h20, 32'h11223344);
    txn("dbg_wr", 1, 32'h20, 4'b1111, 1, 32'h11223344, 0, 0);

    // last owner is DBG: tie goes CPU then DBG
    cpu_set(0, 32'h300, 0, 3'b000);
    dbg_set(0, 32'h400, 0);
    txn("tieA1", 0, 32'h300, 4'b1111, 0, 0, 32'h00000300, 32'h00000300);
    txn("tieA2", 1, 32'h400, 4'b1111, 0, 0, 32'h00000400, 32'h00000400);
    cpu_set(0, 32'h304, 0, 3'b000);
    txn("solo", 0, 32'h304, 4'b1111, 0, 0, 32'h00000304, 32'h00000304);
    // last owner is CPU: tie goes DBG then CPU
    cpu_set(0, 32'h300, 0, 3'b000);
    dbg_set(0, 32'h404, 0);
    txn("tieB1", 1, 32'h404, 4'b1111, 0, 0, 32'h00000404, 32'h00000404);
    txn("tieB2", 0, 32'h300, 4'b1111, 0, 0, 32'h00000301, 32'h00000301);

    // no ack: ready and err after MW wait cycles
    cpu_set(0, 32'h120, 0, 3'b000);
    tick();
    chk("to.en", mem_en, 1'b1);
    for (int i = 0; i < MW; i++) begin
      tick();
      chk("to.rdy_early", cpu_ready, 1'b0);
    end
    tick();
    chk("to.rdy", cpu_ready, 1'b1);
    chk("to.err", err, 1'b1);
    chk("to.crd", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("to.err_off", err, 1'b0);

    cpu_set(0, 32'h10C, 0, 3'b000);
    txn("lw2", 0, 32'h10C, 4'b1111, 0, 0, 32'h77777777, 32'h77777777);

    // misaligned word: no memory access, err with ready, rdata 0
    begin
      logic seen_en;
      logic seen_rdy;
      seen_en = 1'b0;
      seen_rdy = 1'b0;
      cpu_set(0, 32'h101, 0, 3'b000);
      for (int i = 0; i < 4 && !seen_rdy; i++) begin
        tick();
        if (mem_en) seen_en = 1'b1;
        if (cpu_ready) seen_rdy = 1'b1;
      end
      chk("mis.rdy", seen_rdy, 1'b1);
      chk("mis.en", seen_en, 1'b0);
      chk("mis.err", err, 1'b1);
      chk("mis.crd", cpu_rdata, 32'h0);
      chk("mis.drd_hold", dbg_rdata, 32'h00000404);
      cpu_req = 1'b0;
      tick();
    end

    // reset during WAIT aborts; re-issued request is served
    cpu_set(0, 32'h140, 0, 3'b000);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rw.en", mem_en, 1'b0);
    chk("rw.addr", mem_addr, 32'h0);
    chk("rw.crd", cpu_rdata, 32'h0);
    chk("rw.drd", dbg_rdata, 32'h0);
    mem_ack = 1'b1;
    tick();
    chk("rw.rdy", {cpu_ready, dbg_ready, err}, 3'b000);
    mem_ack = 1'b0;
    rst = 1'b1;
    txn("rw.again", 0, 32'h140, 4'b1111, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
